// File: rtl/tanh_act_pkg.sv
// Shared constants for the 4-bit activation stages: output width and signed clip bounds.
package tanh_act_pkg;

  localparam int unsigned ACT_W   = 4;
  localparam int          SAT_MIN = -8;
  localparam int          SAT_MAX = 7;

endpackage

// File: rtl/tanh_prequant.sv
// Auxiliary package for the prequantiser file set; the top-level module is tanh_prequant_4bit.
package tanh_prequant_dummy_pkg;
  localparam int unsigned UNUSED_W = 1;
endpackage

// File: rtl/tanh_sat_counter.sv
// Saturating event counter with synchronous clear; clear has priority over increment.
module tanh_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tanh_prequant_4bit.sv
// Two-stage pre-quantiser feeding the 4-bit tanh stage: S1 rounds and shifts, S2 clips to 4 bits.
module tanh_prequant_4bit
  import tanh_act_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned SHIFT = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [IN_W-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [ACT_W-1:0]       Out1,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sat,
  input  logic                   sat_clr,
  output logic [CNT_W-1:0]       sat_count
);

  localparam int unsigned SW = IN_W + 1;
  localparam logic signed [SW-1:0] RND =
    (SHIFT == 0) ? '0 : (SW'(1) << ((SHIFT == 0) ? 0 : SHIFT - 1));
  localparam logic signed [SW-1:0] LO = SW'(SAT_MIN);
  localparam logic signed [SW-1:0] HI = SW'(SAT_MAX);

  logic                   s1_valid;
  logic signed [SW-1:0]   s1_r;
  logic signed [SW-1:0]   sum_c;
  logic signed [SW-1:0]   r_c;
  logic [ACT_W-1:0]       q_c;
  logic                   sat_c;
  logic                   s1_load;
  logic                   s2_load;

  // Handshake: a stage loads when empty or when its occupant moves on this cycle.
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign s1_load  = in_valid && in_ready;

  // One extra bit of headroom keeps the rounding add from overflowing.
  always_comb begin
    sum_c = {in_data[IN_W-1], in_data} + RND;
    r_c   = sum_c >>> SHIFT;
  end

  always_comb begin
    q_c   = s1_r[ACT_W-1:0];
    sat_c = 1'b0;
    if (s1_r < LO) begin
      q_c   = ACT_W'(SAT_MIN);
      sat_c = 1'b1;
    end else if (s1_r > HI) begin
      q_c   = ACT_W'(SAT_MAX);
      sat_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
    end else begin
      s1_valid <= s1_load || (s1_valid && !s2_load);
      if (s1_load) s1_r <= r_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Out1      <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= s2_load || (out_valid && !out_ready);
      if (s2_load) begin
        Out1    <= q_c;
        out_sat <= sat_c;
      end
    end
  end

  tanh_sat_counter #(
    .CNT_W(CNT_W)
  ) u_sat_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (out_valid && out_ready && out_sat),
    .clr  (sat_clr),
    .count(sat_count)
  );

endmodule

// File: tb/tb_tanh_prequant_4bit.sv
// Randomised and directed bench for tanh_prequant_4bit against an arithmetic reference model.
module tb_tanh_prequant_4bit;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned SHIFT = 4;
  localparam int unsigned CNT_W = 5;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic signed [IN_W-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [3:0]             out1;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_sat;
  logic                   sat_clr;
  logic [CNT_W-1:0]       sat_count;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int model_cnt = 0;

  always #5 clk = ~clk;

  tanh_prequant_4bit #(
    .IN_W (IN_W),
    .SHIFT(SHIFT),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Out1     (out1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sat  (out_sat),
    .sat_clr  (sat_clr),
    .sat_count(sat_count)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Round-half-up division by 2^SHIFT using floor division, before clipping.
  function automatic int ref_round(input int x);
    int div, t, q;
    div = 1 << SHIFT;
    t   = x + ((SHIFT > 0) ? div / 2 : 0);
    q   = t / div;
    if (t < 0 && (t % div) != 0) q = q - 1;
    return q;
  endfunction

  function automatic int ref_out(input int x);
    int r;
    r = ref_round(x);
    if (r < -8) return -8;
    if (r > 7) return 7;
    return r;
  endfunction

  function automatic bit ref_sat(input int x);
    int r;
    r = ref_round(x);
    return (r < -8) || (r > 7);
  endfunction

  // Scoreboard: inputs queue on acceptance, outputs compared in order on delivery.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_cnt = 0;
    end else begin
      int x;
      bit xfer_sat;
      xfer_sat = 1'b0;
      check("sat_count", int'(sat_count), model_cnt);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_output", 1, 0);
        end else begin
          x = exp_q.pop_front();
          check("out1", int'($signed(out1)), ref_out(x));
          check("out_sat", int'(out_sat), int'(ref_sat(x)));
          xfer_sat = ref_sat(x);
        end
      end
      if (sat_clr) model_cnt = 0;
      else if (xfer_sat && model_cnt < CMAX) model_cnt++;
      if (in_valid && in_ready) exp_q.push_back(int'(in_data));
    end
  end

  // One cycle: report handshakes seen before the edge, then return #1 after it.
  task automatic step(output bit acc, output bit ov);
    @(negedge clk);
    acc = in_valid && in_ready;
    ov  = out_valid && out_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x);
    bit acc, ov;
    int n;
    in_data  = IN_W'(x);
    in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      step(acc, ov);
      n++;
    end
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc, ov;
    for (int i = 0; i < 6; i++) step(acc, ov);
  endtask

  initial begin
    bit acc, ov;
    int idx, vals[4], valid_run;
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    #12;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out1", int'(out1), 0);
    check("rst_out_sat", int'(out_sat), 0);
    check("rst_sat_count", int'(sat_count), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    check("in_ready_after_rst", int'(in_ready), 1);

    // Latency: 80 -> 5, visible exactly two edges after acceptance.
    in_data = 16'sd80; in_valid = 1'b1;
    step(acc, ov);
    check("lat_accept", int'(acc), 1);
    in_valid = 1'b0;
    check("lat_cycle1_valid", int'(out_valid), 0);
    step(acc, ov);
    check("lat_cycle2_valid", int'(out_valid), 1);
    check("lat_out1", int'($signed(out1)), 5);
    check("lat_sat", int'(out_sat), 0);
    drain();

    // Clipping and saturation count.
    send(-200); drain();
    check("neg_clip_count", int'(sat_count), 1);
    send(32767); drain();
    check("pos_clip_count", int'(sat_count), 2);

    // Rounding boundaries checked by the scoreboard.
    send(24); send(-24); send(-25); drain();

    // Back-pressure: only two samples fit while the output is stalled.
    vals = '{16, 32, 48, 64};
    idx = 0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = IN_W'(vals[0]);
    for (int i = 0; i < 6; i++) begin
      step(acc, ov);
      if (acc) begin
        idx++;
        if (idx < 4) in_data = IN_W'(vals[idx]); else in_valid = 1'b0;
      end
    end
    check("bp_accepted", idx, 2);
    check("bp_in_ready", int'(in_ready), 0);
    out_ready = 1'b1;
    valid_run = 0;
    for (int i = 0; i < 4; i++) begin
      step(acc, ov);
      if (ov) valid_run++;
      if (acc) begin
        idx++;
        if (idx < 4) in_data = IN_W'(vals[idx]); else in_valid = 1'b0;
      end
    end
    check("bp_no_gaps", valid_run, 4);
    in_valid = 1'b0;
    drain();

    // Counter saturation then clear racing a clipped delivery.
    sat_clr = 1'b1; step(acc, ov); sat_clr = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < CMAX + 6; i++) begin
      in_data = (i % 2 == 0) ? 16'sd4000 : -16'sd4000;
      step(acc, ov);
    end
    in_valid = 1'b0;
    drain();
    check("count_held_max", int'(sat_count), CMAX);
    in_data = 16'sd5000; in_valid = 1'b1;
    step(acc, ov);
    in_valid = 1'b0;
    step(acc, ov);
    check("clr_pending_valid", int'(out_valid), 1);
    sat_clr = 1'b1;
    step(acc, ov);
    sat_clr = 1'b0;
    check("clr_transfer", int'(ov), 1);
    check("clr_wins", int'(sat_count), 0);

    // Randomised traffic with stalls and occasional clears.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      sat_clr   = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 3) == 0) in_data = IN_W'($urandom);
      else in_data = IN_W'(int'($urandom_range(0, 300)) - 150);
      step(acc, ov);
    end
    in_valid = 1'b0; sat_clr = 1'b0; out_ready = 1'b1;
    drain();
    check("queue_empty", exp_q.size(), 0);

    // Reset with both stages full discards everything in flight.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 16'sd3000; step(acc, ov);
    in_data = 16'sd2000; step(acc, ov);
    in_valid = 1'b0;
    check("full_in_ready", int'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_sat_count", int'(sat_count), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    check("post_rst_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    send(100);
    ov = 1'b0;
    for (int i = 0; i < 5 && !out_valid; i++) step(acc, ov);
    check("post_rst_first_valid", int'(out_valid), 1);
    check("post_rst_first_out1", int'($signed(out1)), 6);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
